// File: rtl/simd_multicycle_datapath.sv
// simd_multicycle_datapath
//   Multi-cycle SIMD datapath. One instruction per FSM pass:
//   FETCH -> DECODE -> EXEC -> [MEM] -> WB. HALT is terminal until rst.
//   Owns the PC, the FSM, a 32-entry vector register file of
//   LANES x LANE_BITS, the per-lane ALUs and the branch logic. Decoded
//   control comes from an external control unit that watches 'instr'.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   instr               latched current instruction (to control unit)
//   alu_op, reg_write, mem_write, mem_to_reg, alu_src, branch, imm
//                       decoded control, sampled in DECODE
//   imem_req/addr/rdata/ack   instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/rdata/ack   data access handshake
//   halted              high once the HALT word has been fetched
//   pc                  current program counter
//
// Optional build macro
//   PERF_COUNTERS_EN    adds cycle_cnt / retired_cnt saturating counters
module simd_multicycle_datapath #(
  parameter int LANES     = 4,
  parameter int LANE_BITS = 32,
  parameter int ADDR_BITS = 10,
  localparam int VW       = LANES * LANE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          instr,
  input  logic [2:0]           alu_op,
  input  logic                 reg_write,
  input  logic                 mem_write,
  input  logic                 mem_to_reg,
  input  logic                 alu_src,
  input  logic                 branch,
  input  logic [LANE_BITS-1:0] imm,
  output logic                 imem_req,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_BITS-1:0] dmem_addr,
  output logic [VW-1:0]        dmem_wdata,
  input  logic [VW-1:0]        dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 halted,
  output logic [ADDR_BITS-1:0] pc
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          retired_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_t               state;
  logic [VW-1:0]        rf [32];
  logic [VW-1:0]        a_vec;
  logic [VW-1:0]        b_vec;
  logic [VW-1:0]        r_vec;
  logic [VW-1:0]        ld_vec;
  logic                 z_flag;

  // Control captured in DECODE and held until WB
  logic [2:0]           alu_op_q;
  logic                 reg_write_q;
  logic                 mem_write_q;
  logic                 mem_to_reg_q;
  logic                 alu_src_q;
  logic                 branch_q;
  logic [LANE_BITS-1:0] imm_q;

  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [4:0]           rd;
  logic [VW-1:0]        alu_res;
  logic                 alu_zero;
  logic [ADDR_BITS-1:0] br_off;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign imem_addr  = pc;
  assign dmem_addr  = r_vec[ADDR_BITS-1:0];
  assign dmem_wdata = b_vec;

  // Word-addressed branch offset: imm shifted left by one, truncated to PC width
  assign br_off = {imm_q[ADDR_BITS-2:0], 1'b0};

  function automatic logic [LANE_BITS-1:0] lane_op(
    input logic [2:0]           op,
    input logic [LANE_BITS-1:0] a,
    input logic [LANE_BITS-1:0] b
  );
    logic [LANE_BITS-1:0] res;
    res = '0;
    case (op)
      3'b000: res = a + b;
      3'b001: res = a - b;
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = {a[LANE_BITS-9:0], a[LANE_BITS-1:LANE_BITS-8]};
      3'b110: res = b;
      3'b111: begin
        for (int k = 0; k < LANE_BITS / 8; k++)
          res[k*8 +: 8] = a[(LANE_BITS/8-1-k)*8 +: 8];
      end
    endcase
    return res;
  endfunction

  // Independent lane ALUs; each lane wraps on its own, no carry crosses lanes
  always_comb begin
    alu_res = '0;
    for (int i = 0; i < LANES; i++) begin
      alu_res[i*LANE_BITS +: LANE_BITS] =
        lane_op(alu_op_q, a_vec[i*LANE_BITS +: LANE_BITS],
                alu_src_q ? imm_q : b_vec[i*LANE_BITS +: LANE_BITS]);
    end
    alu_zero = (alu_res == '0);
  end

  // Main FSM. Request lines are registered: a handshake is only completed
  // when ack arrives while our own req is high, so stray acks are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= '0;
      instr        <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      halted       <= 1'b0;
      a_vec        <= '0;
      b_vec        <= '0;
      r_vec        <= '0;
      ld_vec       <= '0;
      z_flag       <= 1'b0;
      alu_op_q     <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      imm_q        <= '0;
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            if (imem_rdata == HALT_WORD) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state  <= DECODE;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          a_vec        <= (rs1 == 5'd0) ? '0 : rf[rs1];
          b_vec        <= (rs2 == 5'd0) ? '0 : rf[rs2];
          alu_op_q     <= alu_op;
          reg_write_q  <= reg_write;
          mem_write_q  <= mem_write;
          mem_to_reg_q <= mem_to_reg;
          alu_src_q    <= alu_src;
          branch_q     <= branch;
          imm_q        <= imm;
          state        <= EXEC;
        end
        EXEC: begin
          r_vec  <= alu_res;
          z_flag <= alu_zero;
          if (mem_write_q || mem_to_reg_q) begin
            dmem_req <= 1'b1;
            dmem_we  <= mem_write_q;
            state    <= MEM;
          end else begin
            state    <= WB;
          end
        end
        MEM: begin
          if (dmem_req && dmem_ack) begin
            if (mem_to_reg_q) ld_vec <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= WB;
          end
        end
        WB: begin
          if (reg_write_q && rd != 5'd0)
            rf[rd] <= mem_to_reg_q ? ld_vec : r_vec;
          if (branch_q && z_flag)
            pc <= pc + br_off;
          else
            pc <= pc + ADDR_BITS'(1);
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          halted   <= 1'b1;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  // Saturating counters: cycles spent running and instructions retired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (!halted && cycle_cnt != 32'hFFFF_FFFF)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (state == WB && retired_cnt != 32'hFFFF_FFFF)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
